// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 16-input round-robin mux-select arbiter.
// Optional grant timeout feature is enabled by defining MUX_ARB_TIMEOUT_EN.
package mux_arb_pkg;

  localparam int SEL_W = 4;
  localparam int N_REQ = 16;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_e;

endpackage

// File: rtl/mux_sel_rr_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching upward from last+1.
// Purely combinational; wraps from the top index back to 0.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] last_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             found_o
);

  logic [SEL_W-1:0] j;

  // Scan farthest offset first so the nearest hit overwrites; offset 16 is last itself.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      j = last_i + SEL_W'(i);
      if (req_i[j]) begin
        idx_o   = j;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter driving the select of a 16:1 mux (IDLE/GRANT/RELEASE).
// Define MUX_ARB_TIMEOUT_EN to force release after TIMEOUT grant cycles.
module mux_sel_rr_arbiter #(
  parameter int N_REQ   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [3:0]       s,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout
);

  import mux_arb_pkg::*;

  if (N_REQ != 16) begin : g_bad_n_req
    $error("mux_sel_rr_arbiter supports only N_REQ=16");
  end
  if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
    $error("mux_sel_rr_arbiter TIMEOUT out of range");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] pick;
  logic             found;
  logic             user_rel;
  logic             force_rel;

  rr_pick u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .idx_o   (pick),
    .found_o (found)
  );

  assign user_rel = done | ~req[s_q];

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  assign force_rel = (state_q == GRANT) &&
                     (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == GRANT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (force_rel && !user_rel) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = GRANT;
          s_d         = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
        end
      end
      GRANT: begin
        if (user_rel || force_rel) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        last_d  = s_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // last resets to 15 so index 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      last_q  <= '1;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  assign s         = s_q;
  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == GRANT);

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Scoreboard bench for mux_sel_rr_arbiter: expected grant indices are queued
// by the stimulus and popped by a monitor on each new grant.
module tb_mux_sel_rr_arbiter;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 15;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done = 1'b0;
  logic [15:0] req = '0;
  logic [3:0]  s;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic        timeout;

  int pass_cnt = 0;
  int total = 0;
  int exp_q[$];
  int mon_e;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  mux_sel_rr_arbiter #(
    .N_REQ   (16),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .s         (s),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each new grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      chk("onehot", 32'((gnt & (gnt - 16'd1)) == 16'd0), 1);
      if (gnt_valid) chk("gnt_eq_s", gnt, 32'(16'd1 << s));
      else chk("gnt_zero", gnt, 0);
`ifndef MUX_ARB_TIMEOUT_EN
      chk("timeout_tied0", timeout, 0);
`endif
      if (gnt_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_s", s, mon_e);
        end
      end
      prev_v = gnt_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(string name);
    int n = 0;
    while (!gnt_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_granted"}, gnt_valid, 1);
  endtask

  task automatic pulse_done(logic [3:0] s_exp);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("rel_gv", gnt_valid, 0);
    chk("rel_gnt", gnt, 0);
    chk("rel_s_hold", s, s_exp);
    step();
    chk("idle_gv", gnt_valid, 0);
  endtask

  initial begin
    #2;
    chk("rst_s", s, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_gv", gnt_valid, 0);
    chk("rst_tmo", timeout, 0);
    repeat (2) step();
    rst_n = 1'b1;

    // single requester, one-cycle latency
    req = 16'h0001;
    exp_q.push_back(0);
    step();
    chk("lat_gv", gnt_valid, 1);
    chk("lat_gnt", gnt, 16'h0001);
    pulse_done(4'd0);
    req = 16'h0000;

    // odd requesters held: 1,3,...,15,1
    req = 16'hAAAA;
    for (int k = 0; k < 9; k++) exp_q.push_back(k < 8 ? 2 * k + 1 : 1);
    for (int k = 0; k < 9; k++) begin
      wait_gnt("aaaa");
      pulse_done(k < 8 ? 4'(2 * k + 1) : 4'd1);
      if (k < 8) begin
        step();
        chk("spacing", gnt_valid, 1);
      end
    end

    // wrap-around: 15, then 0, then 15
    req = 16'h8000;
    exp_q.push_back(15);
    exp_q.push_back(0);
    exp_q.push_back(15);
    wait_gnt("w15");
    req = 16'h8001;
    step();
    chk("stable_s", s, 15);
    chk("stable_gnt", gnt, 16'h8000);
    pulse_done(4'd15);
    wait_gnt("w0");
    pulse_done(4'd0);
    wait_gnt("w15b");
    pulse_done(4'd15);
    req = 16'h0000;

    // req drop releases; done in RELEASE/IDLE ignored
    req = 16'h0020;
    exp_q.push_back(5);
    wait_gnt("r5");
    req = 16'h0040;
    exp_q.push_back(6);
    step();
    chk("drop_rel_gv", gnt_valid, 0);
    chk("drop_rel_s", s, 5);
    done = 1'b1;
    step();
    chk("drop_idle_gv", gnt_valid, 0);
    step();
    done = 1'b0;
    chk("g6_gv", gnt_valid, 1);
    chk("g6_s", s, 6);
    repeat (2) step();
    chk("g6_hold", gnt_valid, 1);
    pulse_done(4'd6);
    req = 16'h0000;

    // asynchronous reset mid-grant
    req = 16'h0200;
    exp_q.push_back(9);
    wait_gnt("r9");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_s", s, 0);
    chk("arst_gv", gnt_valid, 0);
    req = 16'h0201;
    repeat (2) step();
    rst_n = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(9);
    wait_gnt("post_rst0");
    pulse_done(4'd0);
    wait_gnt("post_rst9");
    pulse_done(4'd9);
    req = 16'h0000;

`ifdef MUX_ARB_TIMEOUT_EN
    begin
      int n;
      req = 16'h0010;
      exp_q.push_back(4);
      exp_q.push_back(4);
      wait_gnt("t4");
      n = 0;
      while (gnt_valid && n < 20) begin
        n++;
        step();
      end
      chk("tmo_len", n, TMO);
      chk("tmo_pulse", timeout, 1);
      step();
      chk("tmo_clear", timeout, 0);
      wait_gnt("t4b");
      req = 16'h0000;
    end
`endif

    repeat (4) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mux_sel_rr_arbiter.md
MUX_SEL_RR_ARBITER -- requirements
Module: mux_sel_rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 16, the number of requesters (fixed at 16 = mux inputs; other values unsupported).
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum grant length in cycles (used only when MUX_ARB_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  16  level request per requester; bit i is the requester on mux input w[i].
REQ-006 SHALL have port done  input  1  one-cycle pulse from the granted requester ending its grant.
REQ-007 SHALL have port s  output  4  registered select driven to the 16:1 mux; equals the granted index.
REQ-008 SHALL have port gnt  output  16  registered one-hot grant vector.
REQ-009 SHALL have port gnt_valid  output  1  high while a grant is held.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on forced grant release (tied 0 without MUX_ARB_TIMEOUT_EN).

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, GRANT, RELEASE.
REQ-012 In IDLE with req != 0, SHALL select the first set bit searching upward from (last+1) mod 16, wrapping from 15 to 0, and enter GRANT at the next edge.
REQ-013 On entry to GRANT, s, gnt and gnt_valid SHALL update at the same edge: one-cycle latency from req sampled in IDLE.
REQ-014 In GRANT, s and gnt SHALL remain stable regardless of changes in other req bits.
REQ-015 In GRANT, done=1 or req[s]=0 SHALL move to RELEASE at the next edge, with gnt cleared and gnt_valid=0; s SHALL hold its last value.
REQ-016 RELEASE SHALL last exactly one cycle and then go to IDLE; the last pointer SHALL be updated to s.
REQ-017 done while in IDLE or RELEASE SHALL be ignored.
REQ-018 After release, a sole requester SHALL be re-granted; with several requesters, the previously granted index SHALL have lowest priority.
REQ-019 The minimum grant-to-grant spacing SHALL be 2 idle cycles (RELEASE, IDLE).
REQ-020 gnt SHALL always be zero or one-hot, and SHALL equal (1 << s) whenever gnt_valid=1.

Reset
REQ-021 Asserting rst_n low SHALL immediately force IDLE, s=0, gnt=0, gnt_valid=0, timeout=0, last=15 (so index 0 has first priority), including mid-grant.
REQ-022 Release of rst_n SHALL take effect at the first subsequent rising clk edge.

Configuration
REQ-023 With MUX_ARB_TIMEOUT_EN defined, a cycle counter SHALL clear on GRANT entry; when a grant reaches TIMEOUT cycles without release, the FSM SHALL enter RELEASE and pulse timeout for one cycle.
REQ-024 Without MUX_ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be constant 0, and grants SHALL last until done or req drop.

Structure
REQ-025 Shared package mux_arb_pkg SHALL hold the state enum typedef (IDLE, GRANT, RELEASE), SEL_W=4, N_REQ=16 and the TIMEOUT counter width.
REQ-026 A combinational sub-module rr_pick SHALL take req and last and return the next index plus a found flag.

Verification
REQ-027 Reset then req=16'h0001 -> s=0, gnt=16'h0001, gnt_valid=1 one cycle after req is sampled.
REQ-028 req=16'hAAAA held, done pulsed each grant -> s sequence 1,3,5,...,15,1 with RELEASE+IDLE gaps.
REQ-029 Grant at s=15 then req=16'h8001 -> next grant s=0 (wrap-around), then s=15.
REQ-030 Granted s=5, drop req[5] while req[6] is high -> RELEASE, then grant s=6; done while idle has no effect.
REQ-031 rst_n low mid-grant at s=9 -> gnt=0, s=0, gnt_valid=0 asynchronously, before the next edge.
REQ-032 With MUX_ARB_TIMEOUT_EN and TIMEOUT=4, req=16'h0010 held, no done -> timeout pulses after 4 grant cycles, then s=4 is re-granted.
